ad9866_spi_responder: RTL and testbench
=======================================

Name: ad9866_spi_responder

Overview:
- SPI target (responder) for the 16-bit AD9866 configuration frame.
- It is the far end of the existing AD9866 SPI initiator. It deserialises write frames into a 32x8 register file and serialises register contents back on reads.
- Use cases: loopback/verification target inside the FPGA, and shadow register mirror exposing the live RX/TX gain codes to the rest of the radio.

Parameters:
- SYNC_STAGES, 0, number of input synchroniser flops on sclk/sen_n/sdio. Use 0 when the target shares clk with the initiator; use 2 for an external pin target.
- NUM_REGS, 32, register file depth; address field is 5 bits.
- RST_RXGAIN, 8'h40, reset value of register 0x09.
- RST_TXGAIN, 8'h40, reset value of register 0x0a.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- sclk  in  1  SPI clock from initiator; idle low.
- sen_n  in  1  SPI frame enable, active-low.
- sdio  in  1  serial data, initiator to target, MSB first.
- sdo  out  1  serial read data, target to initiator.
- sdo_oe  out  1  high while read data bits are being driven.
- wr_stb  out  1  one-clk pulse on committed write.
- wr_addr  out  5  address of last committed write.
- wr_data  out  8  data of last committed write.
- frame_err  out  1  one-clk pulse on malformed or aborted frame.
- rx_gain_reg  out  8  live contents of register 0x09.
- tx_gain_reg  out  8  live contents of register 0x0a.

Behaviour:
- Frame format, 16 bits MSB first:
  - bit15: R/W (1 = read).
  - bits14:13: byte count, must be 2'b00.
  - bits12:8: address.
  - bits7:0: data.
- Edge detection:
  - Inputs pass SYNC_STAGES flops, then one history flop.
  - sclk rising edge = current 1 and previous 0. sen_n edges are detected the same way.
  - sdio is sampled on a detected sclk rising edge only.
- FSM states: IDLE, CMD, DATA, WAIT_HI.
  - IDLE -> CMD on sen_n low. Clear bit counter (counts 15 down to 0) and shift register.
  - CMD: shift 8 bits. On the 8th rise, latch rw, the count field and the address.
    - Read: load rd_shift with regfile[addr], assert sdo_oe, drive sdo = rd_shift[7].
    - Then go to DATA.
  - DATA, on each rise:
    - Write: shift sdio in.
    - Read: shift rd_shift left one after the rise, so the next bit is valid before the initiator's next capture.
    - On the 16th rise:
      - Write with count==0: regfile[addr] <= data, wr_stb=1 next clk, wr_addr/wr_data updated.
      - Count!=0 or addr >= NUM_REGS: no write, frame_err=1.
      - Go to WAIT_HI; sdo_oe drops.
  - WAIT_HI: further sclk rises are ignored and raise frame_err once. Go to IDLE on sen_n high.
- Abort: sen_n high in CMD or DATA before the 16th rise -> IDLE, no register change, frame_err pulse, sdo_oe=0 same clk.
- Read of an address >= NUM_REGS returns 8'h00.
- Simultaneous sen_n rise and 16th sclk rise in the same clk: the rise wins, so the frame commits.
- Reset values:
  - FSM IDLE; sdo=0, sdo_oe=0, wr_stb=0, wr_addr=0, wr_data=0, frame_err=0.
  - regfile all 0 except 0x09=RST_RXGAIN and 0x0a=RST_TXGAIN.
- Reset mid-frame discards the frame immediately. After reset release, a frame already in progress (sen_n low) is ignored until sen_n returns high.
- Latency: wr_stb is asserted SYNC_STAGES+2 clks after the initiator's 16th sclk rise.
- rx_gain_reg and tx_gain_reg are direct register outputs.

Decomposition:
- Shared package ad9866_pkg holds:
  - frame field positions (RW_BIT=15, CNT_MSB=14, ADDR_MSB=12, ADDR_LSB=8);
  - register address constants (REG_RXGAIN=5'h09, REG_TXGAIN=5'h0a);
  - FSM state enum, shared with the initiator's constants.
- One sub-module: ad9866_spi_sync (SYNC_STAGES-deep synchroniser plus history flop and edge-detect outputs for the three inputs).
- The register file stays inline.

Test Plan:
- Drive the existing initiator, same clk, SYNC_STAGES=0, through its 20-entry init sequence:
  - 12 wr_stb pulses;
  - regfile[0x04]=8'h31, [0x08]=8'h4b, [0x0c]=8'h41, [0x11]=8'h00;
  - no frame_err.
- Initiator ext_rx_rqst with rx_gain=6'h2a -> rx_gain_reg=8'h6a, wr_addr=5'h09.
- Initiator ext_tx_rqst with tx_gain=6'h15 -> tx_gain_reg=8'h55.
- Read frame 16'h8900 after the rx_gain write -> sdo shifts out 8'h6a MSB first. The initiator's captured dataout=8'h6a and sdo_oe is high for exactly 8 sclk periods.
- Abort: sen_n released after 10 sclk rises of write 16'h0aff -> frame_err pulse, tx_gain_reg unchanged.
- Bad count field: frame 16'h2955 -> frame_err pulse, no wr_stb.
- Reset asserted at bit 12 of a write, released with sen_n still low -> no write. The next clean frame 16'h0977 is accepted, giving rx_gain_reg=8'h77.

Source files
------------

// File: rtl/ad9866_pkg.sv
// Shared AD9866 SPI definitions: frame field positions, register addresses and the
// serial-port FSM state encoding used by both the initiator and the responder.
package ad9866_pkg;

   localparam int unsigned RW_BIT   = 15;
   localparam int unsigned CNT_MSB  = 14;
   localparam int unsigned ADDR_MSB = 12;
   localparam int unsigned ADDR_LSB = 8;
   localparam int unsigned ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

   localparam logic [4:0] REG_RXGAIN = 5'h09;
   localparam logic [4:0] REG_TXGAIN = 5'h0a;

   typedef enum logic [1:0] {
      StIdle,
      StCmd,
      StData,
      StWaitHi
   } spi_state_e;

   typedef struct packed {
      logic       rw;
      logic [1:0] cnt;
      logic [4:0] addr;
   } spi_cmd_t;

   // Split the instruction byte (frame bits 15:8) into its fields.
   function automatic spi_cmd_t decode_cmd(input logic [7:0] cmd_byte);
      spi_cmd_t c;
      c.rw   = cmd_byte[RW_BIT - ADDR_LSB];
      c.cnt  = cmd_byte[CNT_MSB - ADDR_LSB -: 2];
      c.addr = cmd_byte[ADDR_MSB - ADDR_LSB : 0];
      return c;
   endfunction

endpackage

// File: rtl/ad9866_spi_sync.sv
// Optional synchroniser chain plus history flop for sclk/sen_n/sdio, producing
// registered sclk-rise and sen_n-fall strobes aligned with the sampled levels.
module ad9866_spi_sync #(
   parameter int unsigned SYNC_STAGES = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic sclk,
   input  logic sen_n,
   input  logic sdio,
   output logic sclk_rise,
   output logic sen_fall,
   output logic sen_hi,
   output logic sdio_bit
);

   logic [2:0] raw;
   logic [2:0] cur;
   logic [2:0] hist_q;
   logic       sclk_rise_q;
   logic       sen_fall_q;

   assign raw = {sclk, sen_n, sdio};

   if (SYNC_STAGES == 0) begin : g_bypass
      assign cur = raw;
   end else begin : g_sync
      logic [3*SYNC_STAGES-1:0] chain_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            chain_q <= '0;
         end else begin
            chain_q <= (3*SYNC_STAGES)'({chain_q, raw});
         end
      end

      assign cur = chain_q[3*SYNC_STAGES-1 -: 3];
   end

   // sen_n resets low so a frame already running at reset release never shows a fall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q      <= '0;
         sclk_rise_q <= 1'b0;
         sen_fall_q  <= 1'b0;
      end else begin
         hist_q      <= cur;
         sclk_rise_q <= cur[2] & ~hist_q[2];
         sen_fall_q  <= ~cur[1] & hist_q[1];
      end
   end

   assign sclk_rise = sclk_rise_q;
   assign sen_fall  = sen_fall_q;
   assign sen_hi    = hist_q[1];
   assign sdio_bit  = hist_q[0];

endmodule

// File: rtl/ad9866_spi_responder.sv
// AD9866 SPI target: deserialises 16-bit write frames into a register file and
// serialises register contents back on read frames.
module ad9866_spi_responder
   import ad9866_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 0,
   parameter int unsigned NUM_REGS    = 32,
   parameter logic [7:0]  RST_RXGAIN  = 8'h40,
   parameter logic [7:0]  RST_TXGAIN  = 8'h40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sclk,
   input  logic       sen_n,
   input  logic       sdio,
   output logic       sdo,
   output logic       sdo_oe,
   output logic       wr_stb,
   output logic [4:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_err,
   output logic [7:0] rx_gain_reg,
   output logic [7:0] tx_gain_reg
);

   logic sclk_rise;
   logic sen_fall;
   logic sen_hi;
   logic sdio_bit;

   ad9866_spi_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .sclk     (sclk),
      .sen_n    (sen_n),
      .sdio     (sdio),
      .sclk_rise(sclk_rise),
      .sen_fall (sen_fall),
      .sen_hi   (sen_hi),
      .sdio_bit (sdio_bit)
   );

   spi_state_e state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [7:0] rd_shift_q, rd_shift_d;
   logic       sdo_oe_q, sdo_oe_d;
   spi_cmd_t   cmd_q, cmd_d;
   logic       extra_q, extra_d;

   logic [7:0] regs_q [NUM_REGS];
   logic       wr_stb_q;
   logic [4:0] wr_addr_q;
   logic [7:0] wr_data_q;
   logic       frame_err_q;

   logic [7:0] byte_nxt;
   spi_cmd_t   cmd_new;
   logic [7:0] rd_val;
   logic       addr_ok;
   logic       commit_wr;
   logic       err_pulse;

   assign byte_nxt = {shift_q, sdio_bit};
   assign cmd_new  = decode_cmd(byte_nxt);
   assign rd_val   = (32'(cmd_new.addr) < NUM_REGS) ? regs_q[cmd_new.addr] : 8'h00;
   assign addr_ok  = 32'(cmd_q.addr) < NUM_REGS;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rd_shift_d = rd_shift_q;
      sdo_oe_d   = sdo_oe_q;
      cmd_d      = cmd_q;
      extra_d    = extra_q;
      commit_wr  = 1'b0;
      err_pulse  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (sen_fall) begin
               state_d   = StCmd;
               bit_cnt_d = 4'd15;
               shift_d   = '0;
            end
         end
         StCmd: begin
            if (sen_hi) begin
               state_d   = StIdle;
               err_pulse = 1'b1;
            end else if (sclk_rise) begin
               shift_d   = byte_nxt[6:0];
               bit_cnt_d = bit_cnt_q - 4'd1;
               if (bit_cnt_q == 4'd8) begin
                  cmd_d   = cmd_new;
                  state_d = StData;
                  if (cmd_new.rw) begin
                     rd_shift_d = rd_val;
                     sdo_oe_d   = 1'b1;
                  end
               end
            end
         end
         StData: begin
            // The final rise takes priority over a coincident sen_n release.
            if (sclk_rise && bit_cnt_q == 4'd0) begin
               state_d  = StWaitHi;
               sdo_oe_d = 1'b0;
               extra_d  = 1'b0;
               if (cmd_q.cnt != 2'b00 || (!cmd_q.rw && !addr_ok)) begin
                  err_pulse = 1'b1;
               end else if (!cmd_q.rw) begin
                  commit_wr = 1'b1;
               end
            end else if (sen_hi) begin
               state_d   = StIdle;
               sdo_oe_d  = 1'b0;
               err_pulse = 1'b1;
            end else if (sclk_rise) begin
               shift_d   = byte_nxt[6:0];
               bit_cnt_d = bit_cnt_q - 4'd1;
               if (cmd_q.rw) begin
                  rd_shift_d = {rd_shift_q[6:0], 1'b0};
               end
            end
         end
         StWaitHi: begin
            if (sen_hi) begin
               state_d = StIdle;
            end else if (sclk_rise && !extra_q) begin
               err_pulse = 1'b1;
               extra_d   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rd_shift_q <= '0;
         sdo_oe_q   <= 1'b0;
         cmd_q      <= '0;
         extra_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rd_shift_q <= rd_shift_d;
         sdo_oe_q   <= sdo_oe_d;
         cmd_q      <= cmd_d;
         extra_q    <= extra_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i[ADDR_W-1:0]] <= 8'h00;
         end
         regs_q[REG_RXGAIN] <= RST_RXGAIN;
         regs_q[REG_TXGAIN] <= RST_TXGAIN;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         wr_stb_q    <= commit_wr;
         frame_err_q <= err_pulse;
         if (commit_wr) begin
            regs_q[cmd_q.addr] <= byte_nxt;
            wr_addr_q          <= cmd_q.addr;
            wr_data_q          <= byte_nxt;
         end
      end
   end

   assign sdo         = sdo_oe_q & rd_shift_q[7];
   assign sdo_oe      = sdo_oe_q;
   assign wr_stb      = wr_stb_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame_err   = frame_err_q;
   assign rx_gain_reg = regs_q[REG_RXGAIN];
   assign tx_gain_reg = regs_q[REG_TXGAIN];

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Directed bench for ad9866_spi_responder; a behavioural initiator drives frames on the
// same clock with an 8-clk sclk period.
module tb_ad9866_spi_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic       sclk;
   logic       sen_n;
   logic       sdio;
   logic       sdo;
   logic       sdo_oe;
   logic       wr_stb;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_err;
   logic [7:0] rx_gain_reg;
   logic [7:0] tx_gain_reg;

   always #5 clk = ~clk;

   ad9866_spi_responder #(
      .SYNC_STAGES(0),
      .NUM_REGS   (32),
      .RST_RXGAIN (8'h40),
      .RST_TXGAIN (8'h40)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sclk       (sclk),
      .sen_n      (sen_n),
      .sdio       (sdio),
      .sdo        (sdo),
      .sdo_oe     (sdo_oe),
      .wr_stb     (wr_stb),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_err  (frame_err),
      .rx_gain_reg(rx_gain_reg),
      .tx_gain_reg(tx_gain_reg)
   );

   int cyc = 0;
   int stb_total = 0;
   int err_total = 0;
   int oe_total = 0;
   int stb_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_stb) begin
         stb_total++;
         stb_cyc = cyc;
      end
      if (frame_err) err_total++;
      if (sdo_oe) oe_total++;
   end

   int checks = 0;
   int errors = 0;
   int rise16_cyc = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // rst_at/rel_at: rise index before which reset is asserted/released (0 = never).
   task automatic spi_frame(input logic [15:0] frame, input int nrises, input int rst_at,
                            input int rel_at, output logic [7:0] rd);
      rd    = '0;
      sen_n = 1'b0;
      tick(4);
      for (int r = 1; r <= nrises; r++) begin
         if (r == rst_at) reset = 1'b0;
         if (r == rel_at) reset = 1'b1;
         sdio = (r <= 16) ? frame[16-r] : 1'b0;
         tick(4);
         sclk = 1'b1;
         if (r == 16) rise16_cyc = cyc;
         if (r >= 9 && r <= 16) rd[16-r] = sdo;
         tick(4);
         sclk = 1'b0;
      end
      tick(4);
      sen_n = 1'b1;
      tick(6);
   endtask

   logic [15:0] init_tbl [12];
   logic [15:0] rd_frm [4];
   logic [7:0]  rd_exp [4];
   logic [7:0]  rd;
   int b0, e0, o0;

   initial begin
      init_tbl = '{16'h0080, 16'h0100, 16'h0200, 16'h0300, 16'h0431, 16'h0501,
                   16'h0680, 16'h0700, 16'h084b, 16'h0c41, 16'h0d01, 16'h1100};
      rd_frm   = '{16'h8400, 16'h8800, 16'h8c00, 16'h9100};
      rd_exp   = '{8'h31, 8'h4b, 8'h41, 8'h00};

      reset = 1'b0;
      sclk  = 1'b0;
      sen_n = 1'b1;
      sdio  = 1'b0;
      tick(5);
      check("rst_sdo", 32'(sdo), 0);
      check("rst_sdo_oe", 32'(sdo_oe), 0);
      check("rst_wr_stb", 32'(wr_stb), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_rx_gain", 32'(rx_gain_reg), 32'h40);
      check("rst_tx_gain", 32'(tx_gain_reg), 32'h40);
      reset = 1'b1;
      tick(4);

      // Init sequence: twelve writes.
      b0 = stb_total;
      e0 = err_total;
      for (int i = 0; i < 12; i++) spi_frame(init_tbl[i], 16, 0, 0, rd);
      check("init_wr_stb_count", stb_total - b0, 12);
      check("init_frame_err", err_total - e0, 0);
      check("init_wr_addr", 32'(wr_addr), 32'h11);
      check("init_wr_data", 32'(wr_data), 32'h00);
      check("init_rx_gain", 32'(rx_gain_reg), 32'h40);

      b0 = stb_total;
      e0 = err_total;
      for (int i = 0; i < 4; i++) begin
         spi_frame(rd_frm[i], 16, 0, 0, rd);
         check("readback", 32'(rd), 32'(rd_exp[i]));
      end
      check("read_no_wr_stb", stb_total - b0, 0);
      check("read_no_err", err_total - e0, 0);

      // RX gain request: 6'h2a with the enable bit -> 8'h6a.
      spi_frame(16'h096a, 16, 0, 0, rd);
      check("rx_gain", 32'(rx_gain_reg), 32'h6a);
      check("rx_wr_addr", 32'(wr_addr), 32'h09);
      check("rx_wr_data", 32'(wr_data), 32'h6a);
      check("wr_stb_latency", stb_cyc - rise16_cyc, 2);

      spi_frame(16'h0a55, 16, 0, 0, rd);
      check("tx_gain", 32'(tx_gain_reg), 32'h55);

      o0 = oe_total;
      spi_frame(16'h8900, 16, 0, 0, rd);
      check("rd_rx_gain", 32'(rd), 32'h6a);
      check("sdo_oe_clks", oe_total - o0, 64);

      // Abort after 10 rises.
      b0 = stb_total;
      e0 = err_total;
      spi_frame(16'h0aff, 10, 0, 0, rd);
      check("abort_err", err_total - e0, 1);
      check("abort_no_stb", stb_total - b0, 0);
      check("abort_tx_gain", 32'(tx_gain_reg), 32'h55);
      check("abort_sdo_oe", 32'(sdo_oe), 0);

      b0 = stb_total;
      e0 = err_total;
      spi_frame(16'h2955, 16, 0, 0, rd);
      check("badcnt_err", err_total - e0, 1);
      check("badcnt_no_stb", stb_total - b0, 0);
      check("badcnt_rx_gain", 32'(rx_gain_reg), 32'h6a);

      // Two extra rises after the 16th: write commits, one error pulse only.
      b0 = stb_total;
      e0 = err_total;
      spi_frame(16'h0133, 18, 0, 0, rd);
      check("overrun_stb", stb_total - b0, 1);
      check("overrun_err", err_total - e0, 1);
      check("overrun_wr_addr", 32'(wr_addr), 32'h01);
      check("overrun_wr_data", 32'(wr_data), 32'h33);

      // Reset at bit 12, released with sen_n still low.
      b0 = stb_total;
      e0 = err_total;
      spi_frame(16'h0911, 16, 4, 6, rd);
      check("midrst_no_stb", stb_total - b0, 0);
      check("midrst_no_err", err_total - e0, 0);
      check("midrst_rx_gain", 32'(rx_gain_reg), 32'h40);
      check("midrst_tx_gain", 32'(tx_gain_reg), 32'h40);

      b0 = stb_total;
      spi_frame(16'h0977, 16, 0, 0, rd);
      check("post_rst_stb", stb_total - b0, 1);
      check("post_rst_rx_gain", 32'(rx_gain_reg), 32'h77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
